ex_muldiv: RTL

- Parametrised multi-cycle RV32M execute unit that sits beside the single-cycle ALU in the execute stage.
- Implements MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with a shift-add multiplier and a restoring divider, one bit per cycle.
- Asserts hold_flag_o toward control while an operation is in flight, then writes one result back to regs.
- Execute-stage decode drives start_i for opcode INST_TYPE_R_M with funct7 = 7'b0000001.

---
 rtl/ex_muldiv_if.sv | 27 ++
 rtl/ex_muldiv.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_if.sv
// Request/writeback bundle between the execute stage and the multi-cycle RV32M unit.
// The master side is the execute stage; the slave side is ex_muldiv.
interface ex_muldiv_if #(
   parameter int XLEN = 32
);
   logic            start_i;
   logic [2:0]      funct3_i;
   logic [XLEN-1:0] op1_i;
   logic [XLEN-1:0] op2_i;
   logic [4:0]      rd_addr_i;
   logic            flush_i;
   logic [4:0]      rd_addr_o;
   logic [XLEN-1:0] rd_data_o;
   logic            rd_wen_o;
   logic            hold_flag_o;
   logic            busy_o;

   modport master (
      output start_i, funct3_i, op1_i, op2_i, rd_addr_i, flush_i,
      input  rd_addr_o, rd_data_o, rd_wen_o, hold_flag_o, busy_o
   );

   modport slave (
      input  start_i, funct3_i, op1_i, op2_i, rd_addr_i, flush_i,
      output rd_addr_o, rd_data_o, rd_wen_o, hold_flag_o, busy_o
   );
endinterface

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M execute unit: shift-add multiplier and restoring divider, one bit per cycle,
// MSB first, operating on operand magnitudes with the sign reapplied on the final iteration.
module ex_muldiv #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic       clk,
   input  logic       rst,
   ex_muldiv_if.slave mdu
);
   localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN-1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [4:0]        rd_q, rd_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic              neg_q, neg_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              s1_s, s2_s, neg1_s, neg2_s, neg_req_s;
   logic              div_zero_s, ovf_s;
   logic [XLEN-1:0]   mag1_s, mag2_s, special_res_s;
   logic [2*XLEN-1:0] mul_acc_s, div_acc_s, iter_acc_s, mul_full_s;
   logic [XLEN:0]     trial_s, diff_s;
   logic              ge_s, is_div_s, wb_s;
   logic [XLEN-1:0]   div_val_s, final_s;

   // Request decode: sign handling, magnitudes and the cases that bypass iteration.
   always_comb begin
      s1_s       = (mdu.funct3_i == 3'd1) | (mdu.funct3_i == 3'd2) |
                   (mdu.funct3_i == 3'd4) | (mdu.funct3_i == 3'd6);
      s2_s       = (mdu.funct3_i == 3'd1) | (mdu.funct3_i == 3'd4) | (mdu.funct3_i == 3'd6);
      neg1_s     = s1_s & mdu.op1_i[XLEN-1];
      neg2_s     = s2_s & mdu.op2_i[XLEN-1];
      mag1_s     = neg1_s ? -mdu.op1_i : mdu.op1_i;
      mag2_s     = neg2_s ? -mdu.op2_i : mdu.op2_i;
      // A remainder takes the dividend sign; quotient and product take the XOR.
      neg_req_s  = (mdu.funct3_i[2] & mdu.funct3_i[1]) ? neg1_s : (neg1_s ^ neg2_s);
      div_zero_s = mdu.funct3_i[2] & (mdu.op2_i == {XLEN{1'b0}});
      ovf_s      = mdu.funct3_i[2] & ~mdu.funct3_i[0] &
                   (mdu.op1_i == MIN_NEG) & (mdu.op2_i == {XLEN{1'b1}});
      if (div_zero_s) begin
         special_res_s = mdu.funct3_i[1] ? mdu.op1_i : {XLEN{1'b1}};
      end else if (ovf_s) begin
         special_res_s = mdu.funct3_i[1] ? {XLEN{1'b0}} : mdu.op1_i;
      end else begin
         special_res_s = {XLEN{1'b0}};
      end
   end

   // One iteration of either datapath plus the signed result it would yield if it were the last.
   always_comb begin
      is_div_s   = funct3_q[2];
      mul_acc_s  = {acc_q[2*XLEN-2:0], 1'b0} +
                   (b_q[XLEN-1] ? {{XLEN{1'b0}}, a_q} : {(2*XLEN){1'b0}});
      trial_s    = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
      diff_s     = trial_s - {1'b0, b_q};
      ge_s       = ~diff_s[XLEN];
      div_acc_s  = {(ge_s ? diff_s[XLEN-1:0] : trial_s[XLEN-1:0]), acc_q[XLEN-2:0], ge_s};
      iter_acc_s = is_div_s ? div_acc_s : mul_acc_s;
      mul_full_s = neg_q ? -iter_acc_s : iter_acc_s;
      div_val_s  = funct3_q[1] ? iter_acc_s[2*XLEN-1:XLEN] : iter_acc_s[XLEN-1:0];
      if (is_div_s) begin
         final_s = neg_q ? -div_val_s : div_val_s;
      end else if (funct3_q[1:0] == 2'd0) begin
         final_s = mul_full_s[XLEN-1:0];
      end else begin
         final_s = mul_full_s[2*XLEN-1:XLEN];
      end
   end

   // Next-state and datapath register updates.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      funct3_d = funct3_q;
      rd_d     = rd_q;
      a_d      = a_q;
      b_d      = b_q;
      neg_d    = neg_q;
      acc_d    = acc_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (mdu.start_i && !mdu.flush_i) begin
               funct3_d = mdu.funct3_i;
               rd_d     = mdu.rd_addr_i;
               a_d      = mag1_s;
               b_d      = mag2_s;
               neg_d    = neg_req_s;
               acc_d    = {(2*XLEN){1'b0}};
               cnt_d    = CNT_LOAD;
               result_d = special_res_s;
               state_d  = (div_zero_s || ovf_s) ? S_DONE : S_CALC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            if (mdu.flush_i) begin
               state_d = S_IDLE;
            end else begin
               acc_d = iter_acc_s;
               a_d   = is_div_s ? (a_q << 1) : a_q;
               b_d   = is_div_s ? b_q : (b_q << 1);
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == {CNT_W{1'b0}}) begin
                  result_d = final_s;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= {CNT_W{1'b0}};
         funct3_q <= 3'd0;
         rd_q     <= 5'd0;
         a_q      <= {XLEN{1'b0}};
         b_q      <= {XLEN{1'b0}};
         neg_q    <= 1'b0;
         acc_q    <= {(2*XLEN){1'b0}};
         result_q <= {XLEN{1'b0}};
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         funct3_q <= funct3_d;
         rd_q     <= rd_d;
         a_q      <= a_d;
         b_q      <= b_d;
         neg_q    <= neg_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   // Writeback is gated by flush so a killed op never reaches the register file.
   always_comb begin
      wb_s          = (state_q == S_DONE) & ~mdu.flush_i;
      mdu.rd_wen_o  = wb_s;
      mdu.rd_addr_o = wb_s ? rd_q : 5'd0;
      mdu.rd_data_o = wb_s ? result_q : {XLEN{1'b0}};
      mdu.busy_o    = (state_q != S_IDLE);
      case (state_q)
         S_IDLE:  mdu.hold_flag_o = mdu.start_i & ~mdu.flush_i;
         S_CALC:  mdu.hold_flag_o = ~mdu.flush_i;
         default: mdu.hold_flag_o = 1'b0;
      endcase
   end
endmodule
